// File: rtl/proc_trace_buffer_pkg.sv
// Shared types and widths for the proc execution-trace buffer.
// Entry layout matches the proc observable outputs, opcode first.
package proc_trace_buffer_pkg;

  localparam int OPCODE_WIDTH = 6;
  localparam int VALUE_WIDTH  = 16;
  localparam int MEM_WIDTH    = 8;

  localparam int TRACE_ENTRY_W =
    OPCODE_WIDTH + 3 * (MEM_WIDTH + 2) + VALUE_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    POST,
    DONE,
    READ
  } trace_state_t;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] op_code;
    logic [1:0]              source1_choice;
    logic [MEM_WIDTH-1:0]    source1_addr;
    logic [1:0]              source2_choice;
    logic [MEM_WIDTH-1:0]    source2_addr;
    logic [1:0]              dest_choice;
    logic [MEM_WIDTH-1:0]    dest_addr;
    logic [VALUE_WIDTH-1:0]  alu_out;
  } trace_entry_t;

endpackage

// File: rtl/proc_trace_buffer_trace_ram.sv
// Trace storage: flop array, one write port, asynchronous read.
// Contents survive reset; only the control pointers are cleared.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Single write port; storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/proc_trace_buffer.sv
// Trigger-centred circular trace of proc outputs.
// Freezes POST_TRIG samples after a trigger and streams oldest-first.
module proc_trace_buffer
  import proc_trace_buffer_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [OPCODE_WIDTH-1:0]      op_code,
  input  logic [VALUE_WIDTH-1:0]       alu_out,
  input  logic [MEM_WIDTH-1:0]         source1_addr,
  input  logic [MEM_WIDTH-1:0]         source2_addr,
  input  logic [MEM_WIDTH-1:0]         dest_addr,
  input  logic [1:0]                   source1_choice,
  input  logic [1:0]                   source2_choice,
  input  logic [1:0]                   dest_choice,
  input  logic                         arm,
  input  logic [OPCODE_WIDTH-1:0]      trig_opcode,
  input  logic [OPCODE_WIDTH-1:0]      trig_mask,
  input  logic                         trig_force,
  input  logic                         rd_start,
  input  logic                         rd_ready,
  output logic                         rd_valid,
  output logic [TRACE_ENTRY_W-1:0]     rd_data,
  output logic                         rd_last,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         wrapped,
  output logic [2:0]                   state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  trace_state_t              r_state;
  trace_state_t              w_state_nxt;
  logic [AW-1:0]             r_wr_ptr;
  logic [AW-1:0]             r_rd_ptr;
  logic [CW-1:0]             r_count;
  logic [CW-1:0]             r_rem;
  logic [AW-1:0]             r_post;
  logic                      r_wrapped;
  logic                      w_hit;
  logic                      w_we;
  logic                      w_arm_ok;
  logic                      w_rd_go;
  logic                      w_xfer;
  trace_entry_t              w_entry;
  logic [TRACE_ENTRY_W-1:0]  w_rdata;

  assign w_hit = en & (trig_force |
    (((op_code ^ trig_opcode) & trig_mask) == '0));
  assign w_we = en & ((r_state == ARMED) | (r_state == POST));
  assign w_arm_ok = arm & ((r_state == IDLE) | (r_state == DONE));
  assign w_rd_go = rd_start & ~arm & (r_state == DONE);
  assign w_xfer = (r_state == READ) & rd_ready;

  assign w_entry = '{
    op_code:        op_code,
    source1_choice: source1_choice,
    source1_addr:   source1_addr,
    source2_choice: source2_choice,
    source2_addr:   source2_addr,
    dest_choice:    dest_choice,
    dest_addr:      dest_addr,
    alu_out:        alu_out
  };

  trace_ram #(
    .DEPTH (DEPTH),
    .W     (TRACE_ENTRY_W),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_entry),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Capture state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: arm wins over rd_start when both land in DONE
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (arm) w_state_nxt = ARMED;
      ARMED: begin
        if (w_hit)
          w_state_nxt = (POST_TRIG == 0) ? DONE : POST;
      end
      POST: if (en && r_post == AW'(1)) w_state_nxt = DONE;
      DONE: begin
        if (arm)           w_state_nxt = ARMED;
        else if (rd_start) w_state_nxt = READ;
      end
      READ: if (rd_ready && r_rem == CW'(1)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pointers, occupancy and post-trigger countdown
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rem     <= '0;
      r_post    <= '0;
      r_wrapped <= 1'b0;
    end else begin
      if (w_arm_ok) begin
        r_wr_ptr  <= '0;
        r_count   <= '0;
        r_wrapped <= 1'b0;
      end
      if (w_we) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (r_count == CW'(DEPTH)) r_wrapped <= 1'b1;
        else                       r_count   <= r_count + CW'(1);
      end
      if (r_state == ARMED && w_hit)
        r_post <= AW'(POST_TRIG);
      else if (r_state == POST && en)
        r_post <= r_post - AW'(1);
      if (w_rd_go) begin
        r_rd_ptr <= r_wr_ptr - r_count[AW-1:0];
        r_rem    <= r_count;
      end
      if (w_xfer) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_rem    <= r_rem - CW'(1);
      end
    end
  end

  assign rd_valid = (r_state == READ);
  assign rd_last  = rd_valid & (r_rem == CW'(1));
  assign rd_data  = rd_valid ? w_rdata : '0;
  assign count    = r_count;
  assign wrapped  = r_wrapped;
  assign state    = r_state;

endmodule

// File: tb/tb_proc_trace_buffer.sv
// Scoreboard bench for proc_trace_buffer: two instances (post 3 / post 0)
// share stimulus; a queue-based reference predicts state and readout.
module tb_proc_trace_buffer;
  import proc_trace_buffer_pkg::*;

  localparam int D  = 8;
  localparam int EW = TRACE_ENTRY_W;
  localparam int OW = OPCODE_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, arm, trig_force, rd_start, rd_ready;
  logic [OW-1:0] op_code, trig_opcode, trig_mask;
  logic [VALUE_WIDTH-1:0] alu_out;
  logic [MEM_WIDTH-1:0] s1a, s2a, da;
  logic [1:0] s1c, s2c, dc;

  logic          rdv [2];
  logic [EW-1:0] rdd [2];
  logic          rdl [2];
  logic [3:0]    cnt [2];
  logic          wrp [2];
  logic [2:0]    st  [2];

  proc_trace_buffer #(.DEPTH(D), .POST_TRIG(3)) u0 (
    .clk(clk), .rst(rst), .en(en), .op_code(op_code),
    .alu_out(alu_out), .source1_addr(s1a), .source2_addr(s2a),
    .dest_addr(da), .source1_choice(s1c), .source2_choice(s2c),
    .dest_choice(dc), .arm(arm), .trig_opcode(trig_opcode),
    .trig_mask(trig_mask), .trig_force(trig_force),
    .rd_start(rd_start), .rd_ready(rd_ready), .rd_valid(rdv[0]),
    .rd_data(rdd[0]), .rd_last(rdl[0]), .count(cnt[0]),
    .wrapped(wrp[0]), .state(st[0]));

  proc_trace_buffer #(.DEPTH(D), .POST_TRIG(0)) u1 (
    .clk(clk), .rst(rst), .en(en), .op_code(op_code),
    .alu_out(alu_out), .source1_addr(s1a), .source2_addr(s2a),
    .dest_addr(da), .source1_choice(s1c), .source2_choice(s2c),
    .dest_choice(dc), .arm(arm), .trig_opcode(trig_opcode),
    .trig_mask(trig_mask), .trig_force(trig_force),
    .rd_start(rd_start), .rd_ready(rd_ready), .rd_valid(rdv[1]),
    .rd_data(rdd[1]), .rd_last(rdl[1]), .count(cnt[1]),
    .wrapped(wrp[1]), .state(st[1]));

  int errors = 0;
  int checks = 0;

  // Reference: mode 0 idle,1 armed,2 post,3 done,4 read
  int            mode [2];
  int            post [2];
  int            rem  [2];
  bit            mwrap [2];
  logic [EW-1:0] hist  [2][$];
  logic [EW-1:0] exp_q [2][$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic step(int k);
    int pt;
    logic [EW-1:0] e;
    bit hit;
    pt = (k == 0) ? 3 : 0;
    e = {op_code, s1c, s1a, s2c, s2a, dc, da, alu_out};
    hit = en && (trig_force || ((op_code ^ trig_opcode) & trig_mask) == 0);
    if (rst) begin
      mode[k] = 0; post[k] = 0; rem[k] = 0; mwrap[k] = 0;
      hist[k].delete(); exp_q[k].delete();
      return;
    end
    case (mode[k])
      0: if (arm) begin
        hist[k].delete(); mwrap[k] = 0; mode[k] = 1;
      end
      1, 2: if (en) begin
        hist[k].push_back(e);
        if (hist[k].size() > D) begin
          void'(hist[k].pop_front());
          mwrap[k] = 1;
        end
        if (mode[k] == 1) begin
          if (hit) begin
            post[k] = pt;
            mode[k] = (pt == 0) ? 3 : 2;
          end
        end else begin
          post[k]--;
          if (post[k] == 0) mode[k] = 3;
        end
      end
      3: if (arm) begin
        hist[k].delete(); mwrap[k] = 0; mode[k] = 1;
      end else if (rd_start) begin
        foreach (hist[k][i]) exp_q[k].push_back(hist[k][i]);
        rem[k] = hist[k].size();
        mode[k] = 4;
      end
      4: if (rd_ready) begin
        rem[k]--;
        if (rem[k] == 0) mode[k] = 0;
      end
      default: mode[k] = 0;
    endcase
  endtask

  always @(posedge clk) begin
    step(0);
    step(1);
  end

  // Monitor: per-cycle status plus scoreboard pops on transfers
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("state%0d", k), 64'(st[k]), 64'(mode[k]));
      chk($sformatf("count%0d", k), 64'(cnt[k]), 64'(hist[k].size()));
      chk($sformatf("wrapped%0d", k), 64'(wrp[k]), 64'(mwrap[k]));
      chk($sformatf("rd_valid%0d", k), 64'(rdv[k]), 64'(mode[k] == 4));
      if (rdv[k]) begin
        if (exp_q[k].size() == 0) begin
          chk($sformatf("sb_empty%0d", k), 64'(1), 64'(0));
        end else begin
          chk($sformatf("rd_data%0d", k), 64'(rdd[k]), 64'(exp_q[k][0]));
          chk($sformatf("rd_last%0d", k), 64'(rdl[k]),
              64'(exp_q[k].size() == 1));
          if (rd_ready) void'(exp_q[k].pop_front());
        end
      end else begin
        chk($sformatf("idle_data%0d", k), 64'(rdd[k]), 64'(0));
        chk($sformatf("idle_last%0d", k), 64'(rdl[k]), 64'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    arm = 0; rd_start = 0; rst = 0; trig_force = 0;
  endtask

  task automatic rnd_fields();
    alu_out = VALUE_WIDTH'($urandom);
    s1a = MEM_WIDTH'($urandom); s2a = MEM_WIDTH'($urandom);
    da = MEM_WIDTH'($urandom);
    s1c = 2'($urandom); s2c = 2'($urandom); dc = 2'($urandom);
  endtask

  task automatic feed(int start, int n);
    for (int i = 0; i < n; i++) begin
      en = 1; op_code = OW'(start + i);
      rnd_fields();
      tick();
    end
    en = 0;
  endtask

  task automatic do_arm();
    arm = 1;
    tick();
  endtask

  task automatic drain(bit stall);
    bit [3:0] pat;
    int i;
    pat = 4'b1001;
    rd_start = 1;
    tick();
    i = 0;
    while (st[0] == 3'd4 || st[1] == 3'd4) begin
      rd_ready = stall ? pat[3 - (i % 4)] : 1'b1;
      tick();
      i++;
      if (i > 64) begin
        chk("drain_timeout", 64'(1), 64'(0));
        break;
      end
    end
    rd_ready = 1;
  endtask

  initial begin
    rst = 1; en = 0; arm = 0; trig_force = 0; rd_start = 0;
    rd_ready = 1; op_code = 0; trig_opcode = 5;
    trig_mask = '1;
    rnd_fields();
    tick();
    rst = 1;
    tick();
    tick();

    do_arm(); feed(1, 12); drain(0);

    trig_opcode = 14;
    do_arm(); feed(1, 20); drain(0);

    trig_opcode = 5;
    do_arm(); feed(30, 2); feed(5, 1); feed(40, 3); drain(0);

    do_arm(); feed(1, 5);
    repeat (4) tick();
    feed(6, 3); drain(1);

    do_arm(); feed(1, 6);
    rst = 1; tick(); tick();
    do_arm(); feed(1, 8);
    rd_start = 1; tick();
    rd_ready = 0; tick(); tick();
    rst = 1; tick(); tick();
    rd_ready = 1;
    do_arm(); feed(1, 9); drain(1);

    trig_mask = '0;
    do_arm(); feed(20, 4); drain(0);
    trig_mask = '1;

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom % 200) == 0;
      arm = ($urandom % 20) == 0;
      rd_start = ($urandom % 8) == 0;
      en = ($urandom % 4) != 0;
      op_code = OW'($urandom % 16);
      trig_force = ($urandom % 50) == 0;
      rd_ready = ($urandom % 3) != 0;
      if (arm) begin
        trig_opcode = OW'($urandom % 16);
        case ($urandom % 3)
          0: trig_mask = '1;
          1: trig_mask = OW'(3);
          default: trig_mask = '0;
        endcase
      end
      rnd_fields();
      @(posedge clk);
      #1;
    end
    en = 0; arm = 0; rd_start = 0; rst = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
